mux_scan_sequencer: RTL and testbench

//  Upstream driver/checker for the 4:1 MUX stage. On start, latches a data word,

---
 rtl/mux_scan_sequencer.sv | 142 ++++++++++++++
 tb/tb_mux_scan_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: drives a latched word through a WIDTH:1 mux one select
// at a time, rebuilds the word from the sampled mux output and flags mismatch.
module mux_scan_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned SEL_W = 2,
  parameter int unsigned DWELL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic             o,
  output logic [WIDTH-1:0] i,
  output logic [SEL_W-1:0] s,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic             err
);

  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SCAN,
    ST_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_i;
  logic [SEL_W-1:0] r_s;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_dout;
  logic             r_err;

  state_t           w_state_next;
  logic [WIDTH-1:0] w_i_next;
  logic [SEL_W-1:0] w_s_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_busy_next;
  logic             w_done_next;
  logic [WIDTH-1:0] w_dout_next;
  logic             w_err_next;
  logic [WIDTH-1:0] w_sampled;
  logic             w_last_dwell;
  logic             w_last_sel;

  // State and all output registers; reset aborts any scan in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_i     <= '0;
      r_s     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dout  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_i     <= w_i_next;
      r_s     <= w_s_next;
      r_cnt   <= w_cnt_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
      r_dout  <= w_dout_next;
      r_err   <= w_err_next;
    end
  end

  // Next-state and next-register values; the compare uses the word including
  // the bit sampled on the final step so err is valid in the DONE cycle
  always_comb begin
    w_state_next = r_state;
    w_i_next     = r_i;
    w_s_next     = r_s;
    w_cnt_next   = r_cnt;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;
    w_dout_next  = r_dout;
    w_err_next   = r_err;
    w_sampled    = r_dout;
    w_sampled[r_s] = o;
    w_last_dwell = (r_cnt == CNT_LAST);
    w_last_sel   = (r_s == SEL_LAST);

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_i_next     = data_in;
          w_dout_next  = '0;
          w_err_next   = 1'b0;
          w_s_next     = '0;
          w_cnt_next   = '0;
          w_busy_next  = 1'b1;
          w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_s_next     = '0;
        w_cnt_next   = '0;
        w_state_next = ST_SCAN;
      end
      ST_SCAN: begin
        if (w_last_dwell) begin
          w_dout_next = w_sampled;
          w_cnt_next  = '0;
          if (w_last_sel) begin
            w_busy_next  = 1'b0;
            w_done_next  = 1'b1;
            w_err_next   = (w_sampled != r_i);
            w_state_next = ST_DONE;
          end else begin
            w_s_next = r_s + SEL_W'(1);
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        w_s_next     = '0;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign i        = r_i;
  assign s        = r_s;
  assign busy     = r_busy;
  assign done     = r_done;
  assign data_out = r_dout;
  assign err      = r_err;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: DWELL=1 and DWELL=3 instances, each with a
// behavioural 4:1 mux that can be forced stuck-at-0.
module tb_mux_scan_sequencer;

  logic       clk;
  logic       rst;
  logic       start1, start3;
  logic [3:0] din1, din3;
  logic       fault1, fault3;
  logic       o1, o3;
  logic [3:0] i1, i3;
  logic [1:0] s1, s3;
  logic       busy1, busy3, done1, done3, err1, err3;
  logic [3:0] dout1, dout3;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] i;
    logic [1:0] s;
    logic       busy;
    logic       done;
    logic [3:0] dout;
    logic       err;
  } outs_t;

  typedef struct {
    logic [3:0] data;
    bit         fault;
    logic [3:0] exp_dout;
    bit         exp_err;
  } vec_t;

  mux_scan_sequencer #(.WIDTH(4), .SEL_W(2), .DWELL(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .data_in(din1), .o(o1),
    .i(i1), .s(s1), .busy(busy1), .done(done1), .data_out(dout1), .err(err1)
  );

  mux_scan_sequencer #(.WIDTH(4), .SEL_W(2), .DWELL(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .data_in(din3), .o(o3),
    .i(i3), .s(s3), .busy(busy3), .done(done3), .data_out(dout3), .err(err3)
  );

  // Mux under test: ideal selection or stuck-at-0 output
  assign o1 = fault1 ? 1'b0 : i1[s1];
  assign o3 = fault3 ? 1'b0 : i3[s3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic outs_t get_outs(input bit which);
    outs_t q;
    if (which) q = '{i3, s3, busy3, done3, dout3, err3};
    else       q = '{i1, s1, busy1, done1, dout1, err1};
    return q;
  endfunction

  task automatic drive(input bit which, input logic st, input logic [3:0] d);
    if (which) begin start3 = st; din3 = d; end
    else       begin start1 = st; din1 = d; end
  endtask

  task automatic set_fault(input bit which, input bit f);
    if (which) fault3 = f;
    else       fault1 = f;
  endtask

  // Reference: bit k of the rebuilt word is what the mux shows for input k
  function automatic logic [3:0] model_dout(input logic [3:0] d, input bit f);
    logic [3:0] r;
    for (int k = 0; k < 4; k++) r[k] = f ? 1'b0 : d[k];
    return r;
  endfunction

  // One scan, checked every cycle from the start edge to well after done.
  // restart_c > 0 raises a second start (data 0101) in that cycle.
  task automatic run_scan(input bit which, input logic [3:0] data, input bit fault,
                          input logic [3:0] exp_dout, input bit exp_err,
                          input int restart_c);
    int    dw, lat, es, pulses;
    outs_t q;
    dw  = which ? 3 : 1;
    lat = 2 + 4 * dw;
    @(negedge clk);
    set_fault(which, fault);
    drive(which, 1'b1, data);
    @(posedge clk); #1;
    drive(which, 1'b0, ~data);
    for (int c = 1; c <= lat; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (restart_c > 0 && c == restart_c) drive(which, 1'b1, 4'b0101);
      else if (restart_c > 0 && c == restart_c + 1) drive(which, 1'b0, 4'b0101);
      q  = get_outs(which);
      es = (c == 1) ? 0 : (c == lat) ? 3 : (c - 2) / dw;
      chk("scan_i", 32'(q.i), 32'(data));
      chk("scan_s", 32'(q.s), 32'(es));
      chk("scan_busy", 32'(q.busy), 32'(c < lat));
      chk("scan_done", 32'(q.done), 32'(c == lat));
      if (c == 1) begin
        chk("load_dout_clear", 32'(q.dout), 32'd0);
        chk("load_err_clear", 32'(q.err), 32'd0);
      end
      if (c == lat) begin
        chk("done_dout", 32'(q.dout), 32'(exp_dout));
        chk("done_err", 32'(q.err), 32'(exp_err));
      end
    end
    @(posedge clk); #1;
    q = get_outs(which);
    chk("post_s", 32'(q.s), 32'd0);
    chk("post_done", 32'(q.done), 32'd0);
    chk("post_busy", 32'(q.busy), 32'd0);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      q = get_outs(which);
      if (q.done) pulses++;
    end
    chk("extra_done_pulses", 32'(pulses), 32'd0);
    chk("hold_i", 32'(q.i), 32'(data));
    chk("hold_dout", 32'(q.dout), 32'(exp_dout));
    chk("hold_err", 32'(q.err), 32'(exp_err));
  endtask

  task automatic chk_zero(input bit which, input string tag);
    outs_t q;
    q = get_outs(which);
    chk({tag, "_i"}, 32'(q.i), 32'd0);
    chk({tag, "_s"}, 32'(q.s), 32'd0);
    chk({tag, "_busy"}, 32'(q.busy), 32'd0);
    chk({tag, "_done"}, 32'(q.done), 32'd0);
    chk({tag, "_dout"}, 32'(q.dout), 32'd0);
    chk({tag, "_err"}, 32'(q.err), 32'd0);
  endtask

  initial begin
    vec_t       vecs[6];
    bit         found;
    int         pulses;
    logic [3:0] d;
    bit         f, w;

    vecs[0] = '{4'b1010, 1'b0, 4'b1010, 1'b0};
    vecs[1] = '{4'b1111, 1'b1, 4'b0000, 1'b1};
    vecs[2] = '{4'b0000, 1'b0, 4'b0000, 1'b0};
    vecs[3] = '{4'b1111, 1'b0, 4'b1111, 1'b0};
    vecs[4] = '{4'b0101, 1'b1, 4'b0000, 1'b1};
    vecs[5] = '{4'b0000, 1'b1, 4'b0000, 1'b0};

    // Reset held two cycles with start high: reset must win
    rst = 1'b1; start1 = 1'b1; start3 = 1'b1;
    din1 = 4'b1111; din3 = 4'b1111; fault1 = 1'b0; fault3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero(1'b0, "reset1");
    chk_zero(1'b1, "reset3");
    @(negedge clk);
    rst = 1'b0; start1 = 1'b0; start3 = 1'b0;
    @(posedge clk); #1;
    chk_zero(1'b0, "idle1");

    // Table of golden and stuck-at scans on the DWELL=1 instance
    for (int n = 0; n < 6; n++)
      run_scan(1'b0, vecs[n].data, vecs[n].fault, vecs[n].exp_dout, vecs[n].exp_err, 0);

    // Stuck-at error persists, then clears on the next accepted start
    run_scan(1'b0, 4'b1111, 1'b1, 4'b0000, 1'b1, 0);
    run_scan(1'b0, 4'b1010, 1'b0, 4'b1010, 1'b0, 0);

    // Start while busy is ignored: i keeps 1010, one done pulse only
    run_scan(1'b0, 4'b1010, 1'b0, 4'b1010, 1'b0, 2);

    // Abort with reset while s==2, then a clean scan
    @(negedge clk);
    fault1 = 1'b0;
    drive(1'b0, 1'b1, 4'b1010);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'b1010);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (s1 == 2'd2) found = 1'b1;
      else @(negedge clk);
    end
    chk("abort_reach_s2", 32'(found), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_zero(1'b0, "abort");
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done1) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    run_scan(1'b0, 4'b0011, 1'b0, 4'b0011, 1'b0, 0);

    // DWELL=3 instance: each select held three cycles, done 14 cycles in
    run_scan(1'b1, 4'b0110, 1'b0, 4'b0110, 1'b0, 0);
    run_scan(1'b1, 4'b1001, 1'b1, 4'b0000, 1'b1, 0);

    // Random scans on both instances against the reference model
    for (int n = 0; n < 24; n++) begin
      w = n[0];
      d = 4'($urandom_range(0, 15));
      f = 1'($urandom_range(0, 1));
      run_scan(w, d, f, model_dout(d, f), model_dout(d, f) != d, (n % 5 == 0) ? 3 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
